// File: rtl/composite_pkg.sv
// Shared types, default NTSC 240p timing and DAC codes for the composite frame sequencer.
package composite_pkg;

  localparam int unsigned H_W = 11;
  localparam int unsigned V_W = 9;
  localparam int unsigned Y_W = 8;

  localparam int unsigned H_TOTAL_DEF     = 32'd1716;
  localparam int unsigned H_HALF_DEF      = 32'd858;
  localparam int unsigned H_SYNC_DEF      = 32'd127;
  localparam int unsigned EQ_W_DEF        = 32'd62;
  localparam int unsigned BROAD_W_DEF     = 32'd731;
  localparam int unsigned H_ACT_START_DEF = 32'd294;
  localparam int unsigned H_ACT_DEF       = 32'd1382;
  localparam int unsigned V_TOTAL_DEF     = 32'd262;
  localparam int unsigned V_ACT_START_DEF = 32'd21;
  localparam int unsigned V_ACT_DEF       = 32'd240;

  typedef enum logic [2:0] {
    LS_IDLE    = 3'd0,
    LS_EQ_PRE  = 3'd1,
    LS_VSYNC   = 3'd2,
    LS_EQ_POST = 3'd3,
    LS_VBLANK  = 3'd4,
    LS_ACTIVE  = 3'd5
  } line_state_e;

  typedef enum logic [1:0] {
    LVL_BLANK = 2'd0,
    LVL_SYNC  = 2'd1,
    LVL_PIX   = 2'd2
  } level_e;

  // DAC bit order is {270 ohm, 330 ohm, 470 ohm}
  localparam logic [2:0] DAC_SYNC  = 3'b000;
  localparam logic [2:0] DAC_BLANK = 3'b001;
  localparam logic [2:0] DAC_LUMA0 = 3'b001;
  localparam logic [2:0] DAC_LUMA1 = 3'b100;
  localparam logic [2:0] DAC_LUMA2 = 3'b011;
  localparam logic [2:0] DAC_LUMA3 = 3'b110;

  function automatic logic [2:0] luma_to_dac(input logic [1:0] luma);
    logic [2:0] code;
    case (luma)
      2'd0:    code = DAC_LUMA0;
      2'd1:    code = DAC_LUMA1;
      2'd2:    code = DAC_LUMA2;
      2'd3:    code = DAC_LUMA3;
      default: code = DAC_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/composite_frame_sequencer_if.sv
// Pixel request / DAC bundle between the sequencer (slave) and its surroundings (master).
interface composite_frame_sequencer_if;
  import composite_pkg::*;

  logic           en;
  logic [1:0]     luma;
  logic           pix_valid;
  logic [H_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           frame_start;
  logic           busy;
  logic           output_270ohm;
  logic           output_330ohm;
  logic           output_470ohm;

  modport slave (
    input  en, luma,
    output pix_valid, pix_x, pix_y, frame_start, busy,
    output output_270ohm, output_330ohm, output_470ohm
  );

  modport master (
    output en, luma,
    input  pix_valid, pix_x, pix_y, frame_start, busy,
    input  output_270ohm, output_330ohm, output_470ohm
  );

endinterface

// File: rtl/composite_hv_counter.sv
// Horizontal/vertical position counter; exposes the next-cycle position so the
// caller can register its decode in the same cycle the counter moves.
module composite_hv_counter
  import composite_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
  input  logic           refclk,
  input  logic           rst,
  input  logic           en_i,
  output logic [H_W-1:0] h_nxt_o,
  output logic [V_W-1:0] v_nxt_o,
  output logic           run_nxt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ZERO = {H_W{1'b0}};
  localparam logic [V_W-1:0] V_ZERO = {V_W{1'b0}};
  localparam logic [H_W-1:0] H_ONE  = H_W'(1);
  localparam logic [V_W-1:0] V_ONE  = V_W'(1);

  logic [0:0]     st_q, st_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           frame_end_s;

  // next position; en only matters when idle or on the last cycle of a frame
  always_comb begin
    st_d        = st_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_end_s = (st_q == ST_RUN) && (h_q == H_LAST) && (v_q == V_LAST);
    case (st_q)
      ST_IDLE: begin
        h_d = H_ZERO;
        v_d = V_ZERO;
        if (en_i) st_d = ST_RUN;
        else      st_d = ST_IDLE;
      end
      ST_RUN: begin
        if (frame_end_s) begin
          h_d = H_ZERO;
          v_d = V_ZERO;
          if (en_i) st_d = ST_RUN;
          else      st_d = ST_IDLE;
        end else if (h_q == H_LAST) begin
          h_d = H_ZERO;
          v_d = v_q + V_ONE;
        end else begin
          h_d = h_q + H_ONE;
        end
      end
      default: begin
        st_d = ST_IDLE;
        h_d  = H_ZERO;
        v_d  = V_ZERO;
      end
    endcase
  end

  // counter state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      h_q  <= H_ZERO;
      v_q  <= V_ZERO;
    end else begin
      st_q <= st_d;
      h_q  <= h_d;
      v_q  <= v_d;
    end
  end

  assign h_nxt_o   = h_d;
  assign v_nxt_o   = v_d;
  assign run_nxt_o = (st_d == ST_RUN);

endmodule

// File: rtl/composite_frame_sequencer.sv
// 240p NTSC composite frame sequencer: line-type decode, sync/pixel level selection
// and a two-stage pipeline so the DAC shows a position two cycles after it is presented.
module composite_frame_sequencer
  import composite_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_HALF      = H_HALF_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned EQ_W        = EQ_W_DEF,
  parameter int unsigned BROAD_W     = BROAD_W_DEF,
  parameter int unsigned H_ACT_START = H_ACT_START_DEF,
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_ACT_START = V_ACT_START_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF
) (
  input logic                        refclk,
  input logic                        rst,
  composite_frame_sequencer_if.slave bus
);

  localparam logic [H_W-1:0] H_ZERO       = {H_W{1'b0}};
  localparam logic [H_W-1:0] H_SYNC_C     = H_W'(H_SYNC);
  localparam logic [H_W-1:0] EQ_W_C       = H_W'(EQ_W);
  localparam logic [H_W-1:0] BROAD_W_C    = H_W'(BROAD_W);
  localparam logic [H_W-1:0] HALF_C       = H_W'(H_HALF);
  localparam logic [H_W-1:0] EQ2_END_C    = H_W'(H_HALF + EQ_W);
  localparam logic [H_W-1:0] BROAD2_END_C = H_W'(H_HALF + BROAD_W);
  localparam logic [H_W-1:0] ACT_START_C  = H_W'(H_ACT_START);
  localparam logic [H_W-1:0] ACT_END_C    = H_W'(H_ACT_START + H_ACT);
  localparam logic [V_W-1:0] V_ZERO       = {V_W{1'b0}};
  localparam logic [V_W-1:0] V_ACT_START_C = V_W'(V_ACT_START);
  localparam logic [V_W-1:0] V_ACT_END_C   = V_W'(V_ACT_START + V_ACT);

  logic [H_W-1:0] h_d;
  logic [V_W-1:0] v_d;
  logic           run_d;
  line_state_e    line_s;
  logic           sync_s;
  logic           pix_s;
  level_e         lvl_s;

  logic           pix_valid_q;
  logic [H_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic           frame_start_q;
  logic           busy_q;
  level_e         lvl1_q, lvl2_q;
  logic [2:0]     dac_q, dac_d;

  composite_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv_counter (
    .refclk    (refclk),
    .rst       (rst),
    .en_i      (bus.en),
    .h_nxt_o   (h_d),
    .v_nxt_o   (v_d),
    .run_nxt_o (run_d)
  );

  // line type of the position about to be presented
  always_comb begin
    line_s = LS_IDLE;
    if (!run_d)                                              line_s = LS_IDLE;
    else if (v_d < 9'd3)                                     line_s = LS_EQ_PRE;
    else if (v_d < 9'd6)                                     line_s = LS_VSYNC;
    else if (v_d < 9'd9)                                     line_s = LS_EQ_POST;
    else if ((v_d >= V_ACT_START_C) && (v_d < V_ACT_END_C))  line_s = LS_ACTIVE;
    else                                                     line_s = LS_VBLANK;
  end

  // sync windows per line type, then pixel > sync > blank priority
  always_comb begin
    sync_s = 1'b0;
    lvl_s  = LVL_BLANK;
    case (line_s)
      LS_EQ_PRE, LS_EQ_POST:
        sync_s = (h_d < EQ_W_C) || ((h_d >= HALF_C) && (h_d < EQ2_END_C));
      LS_VSYNC:
        sync_s = (h_d < BROAD_W_C) || ((h_d >= HALF_C) && (h_d < BROAD2_END_C));
      LS_VBLANK, LS_ACTIVE:
        sync_s = (h_d < H_SYNC_C);
      default:
        sync_s = 1'b0;
    endcase
    pix_s = (line_s == LS_ACTIVE) && (h_d >= ACT_START_C) && (h_d < ACT_END_C);
    if (pix_s)       lvl_s = LVL_PIX;
    else if (sync_s) lvl_s = LVL_SYNC;
    else             lvl_s = LVL_BLANK;
  end

  // stage 1: coordinates and status for the presented position
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      pix_x_q       <= H_ZERO;
      pix_y_q       <= {Y_W{1'b0}};
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      lvl1_q        <= LVL_BLANK;
    end else begin
      pix_valid_q   <= pix_s;
      if (pix_s) begin
        pix_x_q <= h_d - ACT_START_C;
        pix_y_q <= Y_W'(v_d - V_ACT_START_C);
      end
      frame_start_q <= run_d && (h_d == H_ZERO) && (v_d == V_ZERO);
      busy_q        <= run_d;
      lvl1_q        <= lvl_s;
    end
  end

  // luma arrives one cycle after its coordinate, alongside stage 2
  always_comb begin
    dac_d = DAC_BLANK;
    case (lvl2_q)
      LVL_PIX:  dac_d = luma_to_dac(bus.luma);
      LVL_SYNC: dac_d = DAC_SYNC;
      default:  dac_d = DAC_BLANK;
    endcase
  end

  // stage 2 level and registered DAC code
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lvl2_q <= LVL_BLANK;
      dac_q  <= DAC_BLANK;
    end else begin
      lvl2_q <= lvl1_q;
      dac_q  <= dac_d;
    end
  end

  assign bus.pix_valid     = pix_valid_q;
  assign bus.pix_x         = pix_x_q;
  assign bus.pix_y         = pix_y_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.busy          = busy_q;
  assign bus.output_270ohm = dac_q[2];
  assign bus.output_330ohm = dac_q[1];
  assign bus.output_470ohm = dac_q[0];

endmodule

// File: doc/composite_frame_sequencer.md
Name: composite_frame_sequencer

Overview:
Sequences a complete 262-line progressive NTSC composite frame (240p) at 27 MHz refclk and drives the 3-resistor DAC (270/330/470 ohm).
- Generates equalizing, broad (vertical sync), blanking and active-video line types from a half-line-resolution schedule.
- Requests pixels from the upstream pattern/frame source through a coordinate/valid interface and maps 2-bit luma to DAC codes.
- Replaces the free-running timing counter plus ad-hoc output logic in the composite top level.

Parameters:
H_TOTAL, 1716, refclk cycles per line (63.56 us)
H_HALF, 858, half-line offset for second equalizing/broad pulse
H_SYNC, 127, normal hsync low width (4.7 us)
EQ_W, 62, equalizing pulse low width (2.3 us)
BROAD_W, 731, broad pulse low width (H_HALF - H_SYNC)
H_ACT_START, 294, first active pixel cycle
H_ACT, 1382, active pixels per line
V_TOTAL, 262, lines per frame
V_ACT_START, 21, first active line
V_ACT, 240, active lines

Ports:
refclk  input  1  system clock, 27 MHz
rst  input  1  reset, asynchronous, active-high
en  input  1  run request
luma  input  2  pixel level for the coordinate presented in the previous cycle
pix_valid  output  1  current position is an active pixel
pix_x  output  11  active pixel column, 0..H_ACT-1
pix_y  output  8  active line, 0..V_ACT-1
frame_start  output  1  one-cycle pulse at line 0, h 0
busy  output  1  a frame is in progress
output_270ohm  output  1  DAC bit
output_330ohm  output  1  DAC bit
output_470ohm  output  1  DAC bit

Behaviour:
- Clock and reset: one clock, refclk. rst is asynchronous and active-high.
- Reset values: all outputs 0, except output_470ohm = 1 (blank level). State IDLE, h_cnt = 0, v_cnt = 0.
- DAC codes {270,330,470}: SYNC = 000, BLANK = 001.
  - luma 0 → 001, 1 → 100, 2 → 011, 3 → 110.
- Line states, selected by v_cnt:
  - EQ_PRE: lines 0-2
  - VSYNC: lines 3-5
  - EQ_POST: lines 6-8
  - VBLANK: lines 9-20 and 261
  - ACTIVE: lines 21-260
  - IDLE: outside a frame
- Counters: h_cnt wraps H_TOTAL-1 → 0 and increments v_cnt. v_cnt wraps V_TOTAL-1 → 0.
- SYNC level, by line state:
  - EQ lines: h in [0, EQ_W) or [H_HALF, H_HALF+EQ_W).
  - VSYNC lines: h in [0, BROAD_W) or [H_HALF, H_HALF+BROAD_W).
  - VBLANK/ACTIVE lines: h in [0, H_SYNC).
  - Everything else: BLANK, except active pixels.
- Active pixel: ACTIVE line and h in [H_ACT_START, H_ACT_START+H_ACT).
  - pix_valid = 1.
  - pix_x = h - H_ACT_START.
  - pix_y = v - V_ACT_START.
- Latency:
  - pix_valid, pix_x, pix_y and frame_start are registered and describe position P in cycle N.
  - luma is sampled in cycle N+1.
  - The DAC outputs are registered and show P's level in cycle N+2.
  - The same 2-cycle pipeline applies to sync/blank levels, so all DAC timing is uniform.
  - When pix_valid = 0, pix_x and pix_y hold their last values.
- en handling:
  - IDLE with en = 1: next cycle starts line 0, h 0, and asserts frame_start and busy.
  - en = 0 mid-frame: the frame completes through v = 261, h = 1715, then returns to IDLE (DAC BLANK, busy = 0).
  - en = 1 at frame end: continues into the next frame with no gap cycle.
- rst mid-frame: immediate return to reset values. No partial pulses after reset deasserts.
- Arithmetic: h_cnt 11 bits, v_cnt 9 bits. Comparisons use unsigned, full-width constants.

Decomposition:
- Package composite_pkg holds:
  - line-state enum (IDLE, EQ_PRE, VSYNC, EQ_POST, VBLANK, ACTIVE)
  - DAC code constants (SYNC, BLANK, LUMA0-3)
  - default timing constants
- Sub-module composite_hv_counter: h/v counters with wrap, frame-end flag and run gating.
- State decode, level selection and the output pipeline stay in the top of this block.

Test Plan:
- rst held, en = 1 → DAC 001, pix_valid = 0. Release rst → frame_start one cycle later. After 2 more cycles DAC = 000 for exactly 62 cycles, then 001 until the pulse at h = 858.
- Line 3 → DAC 000 for 731 cycles at h = 0 and again at h = 858. Lines 3-5 show exactly 6 broad pulses.
- Line 21 → pix_valid rises at h = 294 with pix_x = 0, pix_y = 0, and stays high 1382 cycles. Drive luma = 2 → DAC 011 two cycles after pix_valid rise.
- Drive luma = pix_x[6:5] → DAC sequence 001, 100, 011, 110 in 32-cycle runs. Line 260 → pix_y = 239. Line 261 → no pix_valid.
- Deassert en at line 100 → frame completes. busy falls after v = 261, h = 1715. Then DAC holds 001 and frame_start stays low. Re-assert en → frame_start next cycle.
- Assert rst at line 4, h = 500 (mid broad pulse) → DAC 001 asynchronously. After release, the frame restarts at line 0.
